// File: rtl/mul_rr_sequencer_if.sv
// Handshake bundle for mul_rr_sequencer: two operand request channels and one
// tagged result channel, plus the busy status line.
interface mul_rr_sequencer_if #(
  parameter int unsigned OPW = 4
);
  logic             req0_valid;
  logic [OPW-1:0]   req0_a;
  logic [OPW-1:0]   req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [OPW-1:0]   req1_a;
  logic [OPW-1:0]   req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic             res_ready;
  logic [2*OPW-1:0] res_prod;
  logic             res_id;
  logic             busy;

  // Requester/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_prod, res_id, busy
  );

  // Sequencer side
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_prod, res_id, busy
  );
endinterface

// File: rtl/mul_rr_sequencer.sv
// Round-robin sequencer sharing one OPW x OPW unsigned multiplier between two
// requesters. Operands are captured in IDLE, multiplied in MUL, and the tagged
// product is held in HOLD until the consumer accepts it.
// Optional handshake counters (cnt0/cnt1) are enabled by defining MUL_RR_STATS_EN.
module mul_rr_sequencer #(
  parameter int unsigned OPW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mul_rr_sequencer_if.slave     bus
`ifdef MUL_RR_STATS_EN
  ,
  output logic [7:0]            cnt0,
  output logic [7:0]            cnt1
`endif
);

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_a_q, op_a_d;
  logic [OPW-1:0]   op_b_q, op_b_d;
  logic             tag_q, tag_d;
  logic             last_grant_q, last_grant_d;
  logic [2*OPW-1:0] res_prod_q, res_prod_d;
  logic             res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;

  logic             gnt_id;
  logic             ready0, ready1;
  logic             hs0, hs1;
  logic [2*OPW-1:0] prod;

  // Grant: a lone requester wins; under contention the channel not served last wins
  always_comb begin
    gnt_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_grant_q;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end
    ready0 = (state_q == StIdle) && (gnt_id == 1'b0) && bus.req0_valid;
    ready1 = (state_q == StIdle) && (gnt_id == 1'b1) && bus.req1_valid;
    hs0    = ready0;
    hs1    = ready1;
  end

  // Full-width product; operands zero-extended so nothing is truncated
  assign prod = {{OPW{1'b0}}, op_a_q} * {{OPW{1'b0}}, op_b_q};

  // Next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    res_prod_d   = res_prod_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    unique case (state_q)
      StIdle: begin
        if (hs0 || hs1) begin
          op_a_d       = hs1 ? bus.req1_a : bus.req0_a;
          op_b_d       = hs1 ? bus.req1_b : bus.req0_b;
          tag_d        = hs1;
          last_grant_d = hs1;
          state_d      = StMul;
        end
      end
      StMul: begin
        res_prod_d  = prod;
        res_id_d    = tag_q;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_a_q       <= '0;
      op_b_q       <= '0;
      tag_q        <= 1'b0;
      last_grant_q <= 1'b1;
      res_prod_q   <= '0;
      res_id_q     <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
      res_prod_q   <= res_prod_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_prod   = res_prod_q;
  assign bus.res_id     = res_id_q;
  assign bus.busy       = (state_q != StIdle);

`ifdef MUL_RR_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Saturating handshake counters
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (hs0 && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
    if (hs1 && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
